// File: rtl/registrador_pipe.sv
// DEPTH-stage valid/ready pipeline register with per-stage valid bits.
// Empty stages fill even while the output stalls, so capacity is exactly DEPTH words.
module registrador_pipe #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [DATA_WIDTH-1:0]        data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [DATA_WIDTH-1:0]        data_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]                 valid_q, valid_d;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]                 rdy;
   logic                             in_xfer;
   logic [OCC_W-1:0]                 occ;

   // A stage can load if it, or any stage downstream of it, is empty, or the sink takes a word.
   always_comb begin
      logic acc;
      acc = out_ready_i;
      for (int k = DEPTH-1; k >= 0; k--) begin
         acc    = acc || !valid_q[k];
         rdy[k] = acc;
      end
   end

   assign in_ready_o = rdy[0] && !clear_i;
   assign in_xfer    = in_valid_i && in_ready_o;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = '0;
      end else begin
         if (rdy[0]) begin
            valid_d[0] = in_xfer;
            if (in_xfer) data_d[0] = data_i;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
               valid_d[k] = valid_q[k-1];
               if (valid_q[k-1]) data_d[k] = data_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      occ = '0;
      for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(valid_q[k]);
   end

   assign occupancy_o = occ;
   assign out_valid_o = valid_q[DEPTH-1];
   assign data_o      = data_q[DEPTH-1];

endmodule
